rel_mem_acc: RTL and testbench
==============================

REL_MEM_ACC -- requirements
Module: rel_mem_acc

Interface
REQ-001 Parameters (name, default, meaning):
- ROW, 16, PE array rows.
- COL, 16, PE array columns.
- DATA_BITWIDTH, 16, bits per psum word.
- GBF_DATA_BITWIDTH, 512, bits per psum_gbf line.
- PSUM_RF_ADDR_BITWIDTH, 2, PE psum register-file address width.
- DEPTH, 32, psum_gbf lines per buffer.
REQ-002 Derived constants:
- WPL = GBF_DATA_BITWIDTH/DATA_BITWIDTH words per line.
- LPR = ROW*COL/WPL lines per RF entry.
- NRF = 2^PSUM_RF_ADDR_BITWIDTH RF entries.
- Legal configurations: WPL and LPR are powers of 2, and NRF*LPR = DEPTH <= 32.
REQ-003 One clock; reset is asynchronous and active-high. Ports: clk and reset.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1, clock (rising edge).
- reset, in, 1, async active-high reset.
- psum_out, in, DATA_BITWIDTH*ROW*COL, all PE psums for the current psum_rf_addr; PE p occupies [DATA_BITWIDTH*p +: DATA_BITWIDTH].
- pe_psum_finish, in, 1, PE array has completed its psums.
- conv_finish, in, 1, whole convolution done.
- psum_rf_addr, out, PSUM_RF_ADDR_BITWIDTH, RF entry the PE array must present on psum_out.
- su_add_finish, out, 1, one-cycle pulse at end of a write pass.
- out_data, out, GBF_DATA_BITWIDTH, psum_gbf write data.
- psum_gbf_w_en, out, 1, psum_gbf write enable.
- psum_gbf_w_addr, out, 5, psum_gbf write address.
- psum_gbf_w_num, out, 1, target buffer (0 = buf1, 1 = buf2).

Function
REQ-005 Every PE psum is spatially relevant: no adder reduction; psums are copied unchanged into psum_gbf with no arithmetic or truncation.
REQ-006 States: IDLE, WRITE, DONE. All state and outputs are registered on the rising edge of clk.
REQ-007 Counter cnt has log2(DEPTH) bits; psum_rf_addr = cnt / LPR, combinational from cnt.
REQ-008 IDLE transitions:
- pe_psum_finish=1 sampled -> WRITE, cnt=0.
- Else conv_finish=1 sampled -> DONE.
- If both are high, WRITE has priority.
REQ-009 On each WRITE edge:
- psum_gbf_w_en <= 1.
- psum_gbf_w_addr <= cnt, zero-extended to 5 bits.
- out_data word k <= psum_out word ((cnt mod LPR)*WPL + k), for k = 0..WPL-1.
- cnt <= cnt+1.
REQ-010 Data latency: psum_out is sampled in the same cycle psum_rf_addr presents cnt/LPR. The write appears on the outputs one cycle later.
REQ-011 A pass is exactly DEPTH consecutive writes (addresses 0..DEPTH-1, no gaps). Default configuration: 8 lines per RF entry, RF entries 0..3.
REQ-012 On the edge that registers write cnt=DEPTH-1, su_add_finish <= 1, so su_add_finish is high in the same cycle as the last write. The state then leaves WRITE.
REQ-013 On the following edge:
- su_add_finish <= 0 and psum_gbf_w_en <= 0.
- psum_gbf_w_num toggles.
- State -> IDLE, or -> DONE if conv_finish was seen at any time during the pass.
REQ-014 pe_psum_finish asserted during WRITE is ignored; it does not restart or extend the pass.
REQ-015 DONE is terminal until reset:
- w_en=0, su_add_finish=0.
- out_data, psum_gbf_w_addr, psum_gbf_w_num hold.
REQ-016 Outside WRITE: psum_gbf_w_en=0 and out_data holds its last value.
REQ-017 Buffer sequencing: passes alternate buffers 0,1,0,1,... by psum_gbf_w_num.

Reset
REQ-018 On reset assertion, immediately, independent of clk:
- State=IDLE, cnt=0, psum_rf_addr=0.
- su_add_finish=0, psum_gbf_w_en=0, psum_gbf_w_addr=0, psum_gbf_w_num=0, out_data=0.
REQ-019 Reset asserted mid-pass aborts the pass. No su_add_finish pulse and no toggle occur.
REQ-020 After release, the block stays in IDLE until pe_psum_finish is sampled high.

Verification
REQ-021 Basic pass:
- Stimulus: reset; psum_out word p = {rf_addr[1:0], p[7:0]} driven from psum_rf_addr; pulse pe_psum_finish 1 cycle.
- Required: 32 consecutive writes, addr 0..31; line a word k = {a>>3, (a&7)*32+k}; su_add_finish high with addr 31; w_num 0->1 one cycle later.
REQ-022 Back-to-back passes:
- Stimulus: two pe_psum_finish pulses, the second after su_add_finish.
- Required: second pass writes addr 0..31 with w_num=1; after it, w_num returns to 0.
REQ-023 Ignored pulse: pe_psum_finish re-pulsed at write 10 -> pass length still 32 and exactly one su_add_finish.
REQ-024 Convolution end: conv_finish pulsed during a pass -> pass completes all 32 writes, then DONE; later pe_psum_finish produces no writes.
REQ-025 Reset mid-pass:
- Stimulus: reset at write 5.
- Required: w_en=0 and w_num=0 immediately; a fresh pe_psum_finish restarts at addr 0.
REQ-026 Idle conv_finish: conv_finish in IDLE -> DONE; w_en stays 0.

Source files
------------

// File: rtl/rel_mem_acc.sv
// rel_mem_acc: copies the PE array's partial sums into the psum global
// buffer with no accumulation. Every PE psum is spatially relevant, so words
// go out unchanged. One pass writes DEPTH consecutive lines, addresses
// 0..DEPTH-1. It walks the PE psum register file through psum_rf_addr, LPR
// lines per RF entry. Consecutive passes alternate between the two buffers.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   psum_out        all PE psums for the presented RF entry, PE p at word p
//   pe_psum_finish  PE array has finished its psums (starts a pass from IDLE)
//   conv_finish     whole convolution done (ends in DONE)
//   psum_rf_addr    RF entry the PE array must present (combinational, cnt/LPR)
//   su_add_finish   one-cycle pulse coinciding with the last write of a pass
//   out_data        psum_gbf write line
//   psum_gbf_w_en   psum_gbf write enable
//   psum_gbf_w_addr psum_gbf write address
//   psum_gbf_w_num  target buffer (0 = buf1, 1 = buf2)
module rel_mem_acc #(
   parameter int unsigned ROW                   = 16,
   parameter int unsigned COL                   = 16,
   parameter int unsigned DATA_BITWIDTH         = 16,
   parameter int unsigned GBF_DATA_BITWIDTH     = 512,
   parameter int unsigned PSUM_RF_ADDR_BITWIDTH = 2,
   parameter int unsigned DEPTH                 = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
   input  logic                                 pe_psum_finish,
   input  logic                                 conv_finish,
   output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
   output logic                                 su_add_finish,
   output logic [GBF_DATA_BITWIDTH-1:0]         out_data,
   output logic                                 psum_gbf_w_en,
   output logic [4:0]                           psum_gbf_w_addr,
   output logic                                 psum_gbf_w_num
);

   localparam int unsigned WPL    = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
   localparam int unsigned LPR    = (ROW * COL) / WPL;
   localparam int unsigned CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LSEL_W = (LPR > 1) ? $clog2(LPR) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic                     conv_seen;
   logic [LSEL_W-1:0]        line_sel;
   logic [GBF_DATA_BITWIDTH-1:0] lines [LPR];

   // Slice the PE psum vector into gbf-line sized chunks; word k of line j is PE j*WPL+k.
   for (genvar j = 0; j < LPR; j++) begin : g_lines
      assign lines[j] = psum_out[j*GBF_DATA_BITWIDTH +: GBF_DATA_BITWIDTH];
   end

   assign line_sel     = LSEL_W'(32'(cnt) % LPR);
   assign psum_rf_addr = PSUM_RF_ADDR_BITWIDTH'(32'(cnt) / LPR);

   // Control and datapath. The cycle after the last write, su_add_finish is
   // still high. That cycle is the pass wrap-up: it drops w_en, flips the
   // buffer and chooses IDLE or DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         conv_seen       <= 1'b0;
         su_add_finish   <= 1'b0;
         out_data        <= '0;
         psum_gbf_w_en   <= 1'b0;
         psum_gbf_w_addr <= '0;
         psum_gbf_w_num  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               psum_gbf_w_en <= 1'b0;
               su_add_finish <= 1'b0;
               if (pe_psum_finish) begin
                  state     <= WRITE;
                  cnt       <= '0;
                  conv_seen <= 1'b0;
               end else if (conv_finish) begin
                  state <= DONE;
               end
            end
            WRITE: begin
               if (su_add_finish) begin
                  su_add_finish  <= 1'b0;
                  psum_gbf_w_en  <= 1'b0;
                  psum_gbf_w_num <= ~psum_gbf_w_num;
                  state          <= (conv_seen || conv_finish) ? DONE : IDLE;
               end else begin
                  psum_gbf_w_en   <= 1'b1;
                  psum_gbf_w_addr <= 5'(cnt);
                  out_data        <= lines[line_sel];
                  cnt             <= cnt + CNT_W'(1);
                  if (conv_finish) conv_seen <= 1'b1;
                  if (cnt == CNT_W'(DEPTH - 1)) su_add_finish <= 1'b1;
               end
            end
            DONE: begin
               psum_gbf_w_en <= 1'b0;
               su_add_finish <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rel_mem_acc.sv
module tb_rel_mem_acc;

   localparam int unsigned NPE   = 256;
   localparam int unsigned DW    = 16;
   localparam int unsigned GW    = 512;
   localparam int unsigned DEPTH = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [DW*NPE-1:0] psum_out;
   logic            pe_psum_finish = 1'b0;
   logic            conv_finish = 1'b0;
   logic [1:0]      psum_rf_addr;
   logic            su_add_finish;
   logic [GW-1:0]   out_data;
   logic            psum_gbf_w_en;
   logic [4:0]      psum_gbf_w_addr;
   logic            psum_gbf_w_num;

   int  n_vec = 0;
   int  n_err = 0;
   int  wen_cnt = 0;
   int  su_cnt = 0;
   logic [5:0] salt = '0;
   logic       exp_num = 1'b0;

   rel_mem_acc dut (
      .clk            (clk),
      .reset          (reset),
      .psum_out       (psum_out),
      .pe_psum_finish (pe_psum_finish),
      .conv_finish    (conv_finish),
      .psum_rf_addr   (psum_rf_addr),
      .su_add_finish  (su_add_finish),
      .out_data       (out_data),
      .psum_gbf_w_en  (psum_gbf_w_en),
      .psum_gbf_w_addr(psum_gbf_w_addr),
      .psum_gbf_w_num (psum_gbf_w_num)
   );

   always #5 clk = ~clk;

   // PE array model: word p of RF entry r is {salt, r, p[7:0]}.
   always_comb begin
      for (int p = 0; p < NPE; p++)
         psum_out[DW*p +: DW] = {salt, psum_rf_addr, 8'(p)};
   end

   // Count write cycles and finish pulses (values settled before the edge).
   always @(posedge clk) begin
      if (psum_gbf_w_en) wen_cnt <= wen_cnt + 1;
      if (su_add_finish) su_cnt <= su_cnt + 1;
   end

   task automatic check(input string tag, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Gbf line a holds PEs (a%8)*32 .. +31 from RF entry a/8.
   function automatic logic [GW-1:0] exp_line(input int a);
      logic [GW-1:0] r;
      r = '0;
      for (int k = 0; k < GW/DW; k++)
         r[DW*k +: DW] = {salt, 2'(a / 8), 8'((a % 8) * 32 + k)};
      return r;
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_pe();
      @(negedge clk) pe_psum_finish = 1'b1;
      @(negedge clk) pe_psum_finish = 1'b0;
   endtask

   // One full pass; optionally re-pulse pe_psum_finish or conv_finish at a write index.
   task automatic run_pass(input int repulse_at, input int conv_at);
      int t;
      salt = 6'($urandom);
      pulse_pe();
      t = 0;
      while (!psum_gbf_w_en && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!psum_gbf_w_en) begin
         check("start_timeout", 0, 1);
         return;
      end
      for (int i = 0; i < DEPTH; i++) begin
         check("w_en", GW'(psum_gbf_w_en), 1);
         check("w_addr", GW'(psum_gbf_w_addr), GW'(i));
         check("line", out_data, exp_line(i));
         check("su_add_finish", GW'(su_add_finish), GW'(i == DEPTH - 1));
         check("w_num", GW'(psum_gbf_w_num), GW'(exp_num));
         pe_psum_finish = (i == repulse_at);
         conv_finish    = (i == conv_at);
         @(negedge clk);
      end
      pe_psum_finish = 1'b0;
      conv_finish    = 1'b0;
      check("end_w_en", GW'(psum_gbf_w_en), 0);
      check("end_su", GW'(su_add_finish), 0);
      exp_num = ~exp_num;
      check("end_w_num", GW'(psum_gbf_w_num), GW'(exp_num));
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_w_en"}, GW'(psum_gbf_w_en), 0);
      check({tag, "_w_num"}, GW'(psum_gbf_w_num), 0);
      check({tag, "_w_addr"}, GW'(psum_gbf_w_addr), 0);
      check({tag, "_su"}, GW'(su_add_finish), 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_rf_addr"}, GW'(psum_rf_addr), 0);
   endtask

   initial begin
      int w0, s0, t;
      #1;
      reset_checks("reset");
      @(negedge clk) reset = 1'b0;
      idle_cycles(5);
      check("idle_w_en", GW'(wen_cnt), 0);

      // Basic pass then back-to-back pass on the other buffer.
      run_pass(-1, -1);
      run_pass(-1, -1);
      check("b2b_w_num", GW'(psum_gbf_w_num), 0);

      // Ignored re-pulse at write 10, then random-index re-pulses with gaps.
      w0 = wen_cnt; s0 = su_cnt;
      run_pass(10, -1);
      idle_cycles(40);
      check("repulse_writes", GW'(wen_cnt - w0), GW'(DEPTH));
      check("repulse_su", GW'(su_cnt - s0), 1);
      for (int r = 0; r < 3; r++) begin
         idle_cycles(int'($urandom_range(0, 6)));
         run_pass(int'($urandom_range(0, 31)), -1);
      end
      idle_cycles(3);

      // Reset mid-pass with buffer 1 selected.
      if (!exp_num) run_pass(-1, -1);
      pulse_pe();
      t = 0;
      while (!(psum_gbf_w_en && psum_gbf_w_addr == 5'd5) && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("midreset_reach5", GW'(psum_gbf_w_addr), 5);
      s0 = su_cnt;
      reset = 1'b1;
      #1;
      reset_checks("midreset");
      exp_num = 1'b0;
      @(negedge clk) reset = 1'b0;
      w0 = wen_cnt;
      idle_cycles(6);
      check("midreset_idle", GW'(wen_cnt - w0), 0);
      check("midreset_no_su", GW'(su_cnt - s0), 0);
      run_pass(-1, -1);

      // conv_finish during a pass: completes, then DONE ignores pe_psum_finish.
      run_pass(-1, int'($urandom_range(0, 30)));
      w0 = wen_cnt;
      pulse_pe();
      idle_cycles(40);
      check("done_no_writes", GW'(wen_cnt - w0), 0);
      check("done_hold_data", out_data, exp_line(31));
      check("done_hold_addr", GW'(psum_gbf_w_addr), 31);
      check("done_hold_num", GW'(psum_gbf_w_num), GW'(exp_num));
      check("done_su", GW'(su_add_finish), 0);

      // conv_finish in IDLE goes straight to DONE.
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      exp_num = 1'b0;
      @(negedge clk) conv_finish = 1'b1;
      @(negedge clk) conv_finish = 1'b0;
      w0 = wen_cnt;
      pulse_pe();
      idle_cycles(40);
      check("idle_conv_no_writes", GW'(wen_cnt - w0), 0);
      check("idle_conv_w_en", GW'(psum_gbf_w_en), 0);
      check("idle_conv_w_num", GW'(psum_gbf_w_num), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
